regbank_exec: RTL
=================

# regbank_exec

Single-issue execute stage that sits directly downstream of the 4 x 32 register bank and closes the loop back into it. It accepts one operation per handshake and drives the bank's two read-select ports. It computes on the returned operands and writes the result back through the bank's write port one cycle later. Single-cycle ALU ops are handled alongside an iterative 32-step multiplier, with an optional write-back bypass.

## Interface
- DW, 32, datapath width; only 32 is supported. Shift amount is the low 5 bits.
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 MUL, 111 NOP
- sr1, sr2  in  2 each  source register numbers
- dr  in  2  destination register number
- rd_sr1, rd_sr2  out  2 each  to bank read selects; combinational copies of sr1, sr2
- rd_data1, rd_data2  in  DW each  bank read data (combinational from bank)
- wr_en  out  1  to bank write enable
- wr_dr  out  2  to bank destination select
- wr_data  out  DW  to bank write data
- busy  out  1  high while in MUL state

## Operation
- Operands:
  - a = rd_data1 and b = rd_data2, subject to bypass (see Configuration).
- States:
  - IDLE: in_ready=1.
  - MUL: in_ready=0, busy=1.
- IDLE, accept of an ALU op (000-101):
  - Register the result into wr_data and dr into wr_dr; wr_en=1 for exactly the next cycle.
  - Remain in IDLE.
- Arithmetic:
  - All results are mod 2^32.
  - ADD = a+b; SUB = a-b; SLL = a << b[4:0].
  - Carry and overflow are discarded.
- IDLE, accept of NOP:
  - No write; wr_en=0 next cycle.
  - No stall in either configuration.
- IDLE, accept of MUL:
  - Capture a and b into internal multiplicand/multiplier, clear the accumulator and the 5-bit step counter, and go to MUL.
- MUL state:
  - One shift-add step per cycle: if multiplier[0], acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, counter++.
  - After step 31, load wr_data = acc (low 32 bits of product), set wr_dr = captured dr and wr_en=1, and return to IDLE.
- wr_en is never high for two consecutive cycles from a single op. Back-to-back ALU ops produce back-to-back single-cycle writes.
- wr_data and wr_dr hold their last values when wr_en=0.
- Reset:
  - wr_en=0, wr_data=0, wr_dr=0, busy=0, state=IDLE, counter=0.
  - in_ready=0 while rst is high.
  - Reset during MUL aborts it: no write is ever issued for the aborted op.
  - A request presented in the reset cycle is dropped.

## Timing
- ALU op accepted in cycle T -> wr_en=1 in T+1; the bank holds the new value from T+2.
- MUL accepted in T:
  - Steps occur in T+1..T+32 (busy=1, in_ready=0).
  - wr_en=1 and in_ready=1 in T+33; a new op may be accepted in T+33.
- Throughput: one ALU op per cycle with bypass; see Configuration for the stalled case.
- in_valid may drop without being accepted. op, sr1, sr2 and dr are sampled only on the accept edge.

## Configuration
- Macro: REGBANK_EXEC_FWD_EN.
- Defined:
  - Bypass is enabled: a = (wr_en && wr_dr==sr1) ? wr_data : rd_data1, and likewise for b with sr2.
  - A dependent op in the cycle after its producer, including the T+33 MUL write cycle, sees the new value.
  - No hazard stalls.
- Undefined:
  - No bypass.
  - In any cycle where wr_en=1, in_ready=0 (including the MUL write cycle T+33), so reads always follow bank update.
  - Peak ALU throughput is one op per two cycles.

## Test plan
- Reset, then ADD: rst high for 2 cycles -> wr_en=0, wr_data=0, in_ready=0. Preload R1=5 and R2=7, then ADD dr=3 -> wr_en=1, wr_dr=3, wr_data=12 one cycle after accept.
- Arithmetic edges:
  - SUB with R0=0, R1=1, dr=2 -> wr_data=0xFFFFFFFF.
  - SLL with R1=0x1, R2=0x24 -> wr_data=0x10 (shift by 4).
- Back-to-back dependency: ADD R1=R1+R1 then ADD R2=R1+R1, initial R1=3:
  - With FWD_EN: accepts in consecutive cycles, R2=12.
  - Without FWD_EN: in_ready low for one cycle between the accepts, R2=12.
- MUL 0x10001 x 0x10001 into R3:
  - busy=1 for 32 cycles, in_ready=0 throughout.
  - wr_en in T+33 with wr_data=0x00020001.
  - No other wr_en pulse.
- Reset at MUL step 10: no wr_en ever; in_ready=1 the cycle after rst drops; R3 unchanged.
- NOP stream: 4 NOPs accepted in 4 consecutive cycles -> wr_en stays 0 and in_ready stays 1 in both configurations.

Source files
------------

// File: rtl/regbank_exec_if.sv
// Bus between the execute stage, its upstream issuer and the 4 x 32 register bank.
// master = issuer/bank side, slave = regbank_exec.
interface regbank_exec_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [1:0]  sr1;
    logic [1:0]  sr2;
    logic [1:0]  dr;
    logic [1:0]  rd_sr1;
    logic [1:0]  rd_sr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        wr_en;
    logic [1:0]  wr_dr;
    logic [31:0] wr_data;
    logic        busy;

    modport master (
        output in_valid, op, sr1, sr2, dr, rd_data1, rd_data2,
        input  in_ready, rd_sr1, rd_sr2, wr_en, wr_dr, wr_data, busy
    );

    modport slave (
        input  in_valid, op, sr1, sr2, dr, rd_data1, rd_data2,
        output in_ready, rd_sr1, rd_sr2, wr_en, wr_dr, wr_data, busy
    );
endinterface

// File: rtl/regbank_exec.sv
// Single-issue execute stage: ALU ops plus a 32-step shift-add multiplier writing back to the bank.
// Define REGBANK_EXEC_FWD_EN to enable the write-back bypass (otherwise issue stalls while wr_en=1).
module regbank_exec (
    input  logic          i_clk,
    input  logic          i_rst,
    regbank_exec_if.slave exec_if,
    output logic          o_dbg_state
);
    // Handshake: an op transfers on a rising edge where in_valid && in_ready;
    // op/sr1/sr2/dr are sampled only on that edge, and in_valid may drop unaccepted.

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_wr_en;
    logic [1:0]  r_wr_dr;
    logic [31:0] r_wr_data;
    logic        r_busy;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [4:0]  r_cnt;
    logic [1:0]  r_mul_dr;

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_alu;
    logic [31:0] w_step_acc;
    logic        w_in_ready;
    logic        w_accept;

`ifdef REGBANK_EXEC_FWD_EN
    assign w_a        = (r_wr_en && (r_wr_dr == exec_if.sr1)) ? r_wr_data : exec_if.rd_data1;
    assign w_b        = (r_wr_en && (r_wr_dr == exec_if.sr2)) ? r_wr_data : exec_if.rd_data2;
    assign w_in_ready = (r_state == S_IDLE) && !i_rst;
`else
    // Without bypass, hold off issue during the write cycle so reads see the updated bank.
    assign w_a        = exec_if.rd_data1;
    assign w_b        = exec_if.rd_data2;
    assign w_in_ready = (r_state == S_IDLE) && !i_rst && !r_wr_en;
`endif

    assign w_accept   = exec_if.in_valid && w_in_ready;
    assign w_step_acc = r_acc + (r_mplier[0] ? r_mcand : 32'd0);

    always_comb begin
        w_alu = 32'd0;
        case (exec_if.op)
            OP_ADD:  w_alu = w_a + w_b;
            OP_SUB:  w_alu = w_a - w_b;
            OP_AND:  w_alu = w_a & w_b;
            OP_OR:   w_alu = w_a | w_b;
            OP_XOR:  w_alu = w_a ^ w_b;
            OP_SLL:  w_alu = w_a << w_b[4:0];
            default: w_alu = 32'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_wr_en   <= 1'b0;
            r_wr_dr   <= 2'd0;
            r_wr_data <= 32'd0;
            r_busy    <= 1'b0;
            r_mcand   <= 32'd0;
            r_mplier  <= 32'd0;
            r_acc     <= 32'd0;
            r_cnt     <= 5'd0;
            r_mul_dr  <= 2'd0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (exec_if.op == OP_MUL) begin
                            r_mcand  <= w_a;
                            r_mplier <= w_b;
                            r_acc    <= 32'd0;
                            r_cnt    <= 5'd0;
                            r_mul_dr <= exec_if.dr;
                            r_busy   <= 1'b1;
                            r_state  <= S_MUL;
                        end else if (exec_if.op != OP_NOP) begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= w_alu;
                            r_wr_dr   <= exec_if.dr;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_step_acc;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    // Step 31 is the last: publish the product directly from the step sum.
                    if (r_cnt == 5'd31) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= w_step_acc;
                        r_wr_dr   <= r_mul_dr;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign exec_if.in_ready = w_in_ready;
    assign exec_if.rd_sr1   = exec_if.sr1;
    assign exec_if.rd_sr2   = exec_if.sr2;
    assign exec_if.wr_en    = r_wr_en;
    assign exec_if.wr_dr    = r_wr_dr;
    assign exec_if.wr_data  = r_wr_data;
    assign exec_if.busy     = r_busy;
    assign o_dbg_state      = r_state;
endmodule
